// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and result-side signals of the UART receiver.
//   rx, tick          : serial input and oversampling pulse (driven by master)
//   dout, rx_done     : received word and its one-cycle valid strobe
//   rx_busy           : frame reception in progress
//   parity_err,
//   frame_err         : status of the last received frame
// modport slave is the receiver; modport master is whoever feeds the line.
interface uart_rx_if #(
   parameter int DATA_WD = 8
);
   logic               rx;
   logic               tick;
   logic [DATA_WD-1:0] dout;
   logic               rx_done;
   logic               rx_busy;
   logic               parity_err;
   logic               frame_err;

   modport master (
      output rx, tick,
      input  dout, rx_done, rx_busy, parity_err, frame_err
   );

   modport slave (
      input  rx, tick,
      output dout, rx_done, rx_busy, parity_err, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, framing-compatible with uart_tx.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   bus        : uart_rx_if.slave (rx/tick in; dout, rx_done, rx_busy,
//                parity_err, frame_err out)
// parity: 1 = parity bit is XOR of data, 2 = inverted XOR, other = none.
module uart_rx #(
   parameter int oversampling_rate = 16,
   parameter int data_wd           = 8,
   parameter int parity            = 0
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);

   localparam int TW     = $clog2(oversampling_rate);
   localparam int BW     = $clog2(data_wd);
   localparam bit PAR_EN = (parity == 1) || (parity == 2);

   localparam logic [TW-1:0] T_HALF   = TW'(oversampling_rate/2 - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(oversampling_rate - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(data_wd - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_n;
   logic                 rx_meta, rx_s;
   logic [TW-1:0]        tick_count, tick_count_n;
   logic [BW-1:0]        bit_index, bit_index_n;
   logic [data_wd-1:0]   shreg, shreg_n;
   logic                 par_mis, par_mis_n;
   logic                 wait_high, wait_high_n;
   logic [data_wd-1:0]   dout_q, dout_n;
   logic                 done_q, done_n;
   logic                 perr_q, perr_n;
   logic                 ferr_q, ferr_n;
   logic                 par_exp;

   // rx is asynchronous; idle-high reset value keeps reset from looking like a start bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   assign par_exp = (parity == 1) ? ^shreg : ~^shreg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tick_count <= '0;
         bit_index  <= '0;
         shreg      <= '0;
         par_mis    <= 1'b0;
         wait_high  <= 1'b0;
         dout_q     <= '0;
         done_q     <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state      <= state_n;
         tick_count <= tick_count_n;
         bit_index  <= bit_index_n;
         shreg      <= shreg_n;
         par_mis    <= par_mis_n;
         wait_high  <= wait_high_n;
         dout_q     <= dout_n;
         done_q     <= done_n;
         perr_q     <= perr_n;
         ferr_q     <= ferr_n;
      end
   end

   always_comb begin
      state_n      = state;
      tick_count_n = tick_count;
      bit_index_n  = bit_index;
      shreg_n      = shreg;
      par_mis_n    = par_mis;
      wait_high_n  = wait_high;
      dout_n       = dout_q;
      done_n       = 1'b0;
      perr_n       = perr_q;
      ferr_n       = ferr_q;
      case (state)
         IDLE: begin
            tick_count_n = '0;
            bit_index_n  = '0;
            par_mis_n    = 1'b0;
            // after a framing error the line must go high before a new start is armed,
            // so a held break yields only one errored frame
            if (rx_s)
               wait_high_n = 1'b0;
            else if (!wait_high)
               state_n = START;
         end
         START: begin
            if (bus.tick) begin
               if (tick_count == T_HALF) begin
                  tick_count_n = '0;
                  state_n      = rx_s ? IDLE : DATA;   // high at mid start bit = glitch
               end else begin
                  tick_count_n = tick_count + 1'b1;
               end
            end
         end
         DATA: begin
            if (bus.tick) begin
               if (tick_count == T_LAST) begin
                  tick_count_n         = '0;
                  shreg_n[bit_index]   = rx_s;
                  if (bit_index == BIT_LAST) begin
                     bit_index_n = '0;
                     state_n     = PAR_EN ? PARITY : STOP;
                  end else begin
                     bit_index_n = bit_index + 1'b1;
                  end
               end else begin
                  tick_count_n = tick_count + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bus.tick) begin
               if (tick_count == T_LAST) begin
                  tick_count_n = '0;
                  par_mis_n    = (rx_s != par_exp);
                  state_n      = STOP;
               end else begin
                  tick_count_n = tick_count + 1'b1;
               end
            end
         end
         STOP: begin
            if (bus.tick) begin
               if (tick_count == T_LAST) begin
                  // back to IDLE at mid stop bit: half a bit of slack before the next start
                  tick_count_n = '0;
                  bit_index_n  = '0;
                  dout_n       = shreg;
                  perr_n       = par_mis;
                  ferr_n       = !rx_s;
                  wait_high_n  = !rx_s;
                  done_n       = 1'b1;
                  state_n      = IDLE;
               end else begin
                  tick_count_n = tick_count + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.dout       = dout_q;
   assign bus.rx_done    = done_q;
   assign bus.rx_busy    = (state != IDLE);
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Two receivers share clk/rst/tick:
// dut_n is 8N1, dut_p uses inverted parity (parity = 2).
module tb_uart_rx;
   localparam int OSR  = 16;
   localparam int DW   = 8;
   localparam int TPER = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick = 1'b0;
   int unsigned tdiv = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tdiv <= (tdiv == TPER-1) ? 0 : tdiv + 1;
      tick <= (tdiv == TPER-1);
   end

   uart_rx_if #(.DATA_WD(DW)) ifn ();
   uart_rx_if #(.DATA_WD(DW)) ifp ();

   assign ifn.tick = tick;
   assign ifp.tick = tick;

   uart_rx #(.oversampling_rate(OSR), .data_wd(DW), .parity(0)) dut_n (
      .clk(clk), .rst(rst), .bus(ifn.slave));
   uart_rx #(.oversampling_rate(OSR), .data_wd(DW), .parity(2)) dut_p (
      .clk(clk), .rst(rst), .bus(ifp.slave));

   typedef struct packed {
      logic [DW-1:0] d;
      logic          pe;
      logic          fe;
   } exp_t;

   exp_t q_n[$];
   exp_t q_p[$];
   exp_t e_n, e_p;
   int   checks = 0;
   int   errors = 0;
   int   done_n = 0;
   int   done_p = 0;
   bit   abort_tx = 1'b0;

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!tick) @(posedge clk);
      end
   endtask

   task automatic set_rx(input bit inst, input logic v);
      @(negedge clk);
      if (inst) ifp.rx = v;
      else      ifn.rx = v;
   endtask

   // serial model of uart_tx: start, data LSB first, optional parity, stop
   task automatic send(input bit inst, input logic [DW-1:0] d, input bit use_par,
                       input logic pbit, input logic stopb);
      logic [DW+2:0] bits;
      int n;
      bits    = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) bits[1+i] = d[i];
      n = DW + 1;
      if (use_par) begin bits[n] = pbit; n++; end
      bits[n] = stopb;
      n++;
      for (int i = 0; i < n; i++) begin
         if (abort_tx) break;
         set_rx(inst, bits[i]);
         wait_ticks(OSR);
      end
   endtask

   task automatic expect_rx(input bit inst, input logic [DW-1:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d = d; e.pe = pe; e.fe = fe;
      if (inst) q_p.push_back(e);
      else      q_n.push_back(e);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (ifn.rx_done) begin
            done_n++;
            checks++;
            if (q_n.size() == 0) begin
               errors++;
               $display("FAIL n_unexpected_done dout=%h pe=%b fe=%b", ifn.dout, ifn.parity_err, ifn.frame_err);
            end else begin
               e_n = q_n.pop_front();
               if ({ifn.dout, ifn.parity_err, ifn.frame_err} !== e_n) begin
                  errors++;
                  $display("FAIL n_frame got dout=%h pe=%b fe=%b want dout=%h pe=%b fe=%b",
                           ifn.dout, ifn.parity_err, ifn.frame_err, e_n.d, e_n.pe, e_n.fe);
               end
            end
         end
         if (ifp.rx_done) begin
            done_p++;
            checks++;
            if (q_p.size() == 0) begin
               errors++;
               $display("FAIL p_unexpected_done dout=%h pe=%b fe=%b", ifp.dout, ifp.parity_err, ifp.frame_err);
            end else begin
               e_p = q_p.pop_front();
               if ({ifp.dout, ifp.parity_err, ifp.frame_err} !== e_p) begin
                  errors++;
                  $display("FAIL p_frame got dout=%h pe=%b fe=%b want dout=%h pe=%b fe=%b",
                           ifp.dout, ifp.parity_err, ifp.frame_err, e_p.d, e_p.pe, e_p.fe);
               end
            end
         end
      end
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((q_n.size() != 0 || q_p.size() != 0) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (q_n.size() != 0 || q_p.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending n=%0d p=%0d want 0", name, q_n.size(), q_p.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ifn.rx = i[0];
         ifp.rx = ~i[0];
      end
      checks += 2;
      if ({ifn.dout, ifn.rx_done, ifn.rx_busy, ifn.parity_err, ifn.frame_err} !== '0) begin
         errors++;
         $display("FAIL reset_n got %h want 0", {ifn.dout, ifn.rx_done, ifn.rx_busy, ifn.parity_err, ifn.frame_err});
      end
      if ({ifp.dout, ifp.rx_done, ifp.rx_busy, ifp.parity_err, ifp.frame_err} !== '0) begin
         errors++;
         $display("FAIL reset_p got %h want 0", {ifp.dout, ifp.rx_done, ifp.rx_busy, ifp.parity_err, ifp.frame_err});
      end
      ifn.rx = 1'b1;
      ifp.rx = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (ifn.rx_busy !== 1'b0 || ifp.rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy got n=%b p=%b want 0", ifn.rx_busy, ifp.rx_busy);
      end
   endtask

   task automatic test_8n1_latency();
      expect_rx(0, 8'hA5, 1'b0, 1'b0);
      fork
         send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
         begin
            int k = 0;
            int t = 0;
            int gap = 0;
            while (!ifn.rx_busy && k < 2000) begin @(negedge clk); k++; end
            k = 0;
            while (!ifn.rx_done && k < 3000) begin
               if (tick) begin t++; gap = 0; end
               else gap++;
               @(negedge clk);
               k++;
            end
            checks += 3;
            if (t != 152) begin
               errors++;
               $display("FAIL latency_ticks got %0d want 152", t);
            end
            if (gap != 0) begin
               errors++;
               $display("FAIL latency_clk got %0d extra clk want 0", gap);
            end
            @(negedge clk);
            if (ifn.rx_done !== 1'b0) begin
               errors++;
               $display("FAIL done_width got %b want 0", ifn.rx_done);
            end
         end
      join
      drain("a5");
   endtask

   task automatic test_back_to_back();
      expect_rx(0, 8'h00, 1'b0, 1'b0);
      expect_rx(0, 8'hFF, 1'b0, 1'b0);
      send(0, 8'h00, 1'b0, 1'b0, 1'b1);
      send(0, 8'hFF, 1'b0, 1'b0, 1'b1);
      drain("b2b");
   endtask

   task automatic test_parity();
      // 0x3C has four ones; inverted parity bit is 1
      expect_rx(1, 8'h3C, 1'b0, 1'b0);
      expect_rx(1, 8'h3C, 1'b1, 1'b0);
      send(1, 8'h3C, 1'b1, 1'b1, 1'b1);
      send(1, 8'h3C, 1'b1, 1'b0, 1'b1);
      drain("parity");
      repeat (10) @(negedge clk);
      checks++;
      if (ifp.parity_err !== 1'b1 || ifp.dout !== 8'h3C) begin
         errors++;
         $display("FAIL parity_hold got pe=%b dout=%h want pe=1 dout=3c", ifp.parity_err, ifp.dout);
      end
   endtask

   task automatic test_break();
      int d0 = done_n;
      expect_rx(0, 8'h5A, 1'b0, 1'b1);
      send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
      wait_ticks(3 * 10 * OSR);
      set_rx(0, 1'b1);
      wait_ticks(2 * OSR);
      checks++;
      if (done_n - d0 != 1) begin
         errors++;
         $display("FAIL break_frames got %0d want 1", done_n - d0);
      end
      expect_rx(0, 8'h81, 1'b0, 1'b0);
      send(0, 8'h81, 1'b0, 1'b0, 1'b1);
      drain("break");
      checks++;
      if (done_n - d0 != 2 || ifn.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL after_break got frames=%0d fe=%b want 2 0", done_n - d0, ifn.frame_err);
      end
   endtask

   task automatic test_glitch();
      int d0 = done_n;
      set_rx(0, 1'b0);
      wait_ticks(4);
      set_rx(0, 1'b1);
      checks++;
      if (ifn.rx_busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy got %b want 1", ifn.rx_busy);
      end
      wait_ticks(12);
      @(negedge clk);
      checks++;
      if (ifn.rx_busy !== 1'b0 || done_n != d0) begin
         errors++;
         $display("FAIL glitch_idle got busy=%b frames=%0d want 0 0", ifn.rx_busy, done_n - d0);
      end
      expect_rx(0, 8'h42, 1'b0, 1'b0);
      send(0, 8'h42, 1'b0, 1'b0, 1'b1);
      drain("glitch");
   endtask

   task automatic test_reset_mid();
      int d0 = done_n;
      fork
         send(0, 8'h96, 1'b0, 1'b0, 1'b1);
         begin
            wait_ticks(OSR + 3*OSR + OSR/2);   // mid data bit 3
            @(negedge clk);
            abort_tx = 1'b1;
            rst = 1'b0;
            @(negedge clk);
            checks += 2;
            if ({ifn.dout, ifn.rx_done, ifn.rx_busy, ifn.parity_err, ifn.frame_err} !== '0) begin
               errors++;
               $display("FAIL midreset_n got %h want 0", {ifn.dout, ifn.rx_done, ifn.rx_busy, ifn.parity_err, ifn.frame_err});
            end
            if ({ifp.dout, ifp.parity_err} !== '0) begin
               errors++;
               $display("FAIL midreset_p got dout=%h pe=%b want 0", ifp.dout, ifp.parity_err);
            end
         end
      join
      ifn.rx = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      abort_tx = 1'b0;
      wait_ticks(2 * OSR);
      checks++;
      if (done_n != d0) begin
         errors++;
         $display("FAIL midreset_done got %0d want 0", done_n - d0);
      end
      expect_rx(0, 8'hC3, 1'b0, 1'b0);
      send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
      drain("loopback");
      checks++;
      if (ifn.dout !== 8'hC3) begin
         errors++;
         $display("FAIL loopback_dout got %h want c3", ifn.dout);
      end
   endtask

   initial begin
      ifn.rx = 1'b1;
      ifp.rx = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_8n1_latency();
      test_back_to_back();
      test_parity();
      test_break();
      test_glitch();
      test_reset_mid();
      repeat (20) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
